probe_capture_buffer: RTL and testbench

//  Parametrised on-chip capture block: samples a PROBE_W-bit debug bus into a circular RAM.

---
 rtl/probe_capture_pkg.sv | 17 +
 rtl/capture_ram.sv | 29 ++
 rtl/probe_capture_buffer.sv | 177 +++++++++++++++++
 tb/tb_probe_capture_buffer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_capture_pkg.sv
// Shared state codes and trigger-mode encodings for the probe capture buffer.
package probe_capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  localparam logic [1:0] TRIG_LEVEL = 2'b00;
  localparam logic [1:0] TRIG_RISE  = 2'b01;
  localparam logic [1:0] TRIG_FALL  = 2'b10;
  localparam logic [1:0] TRIG_EXT   = 2'b11;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port (1-cycle latency).
module capture_ram #(
  parameter int PROBE_W = 12,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PROBE_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PROBE_W-1:0] rd_data
);

  logic [PROBE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register reset keeps rd_data at zero until the first pop.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/probe_capture_buffer.sv
// Circular capture of a debug probe bus with mask/compare trigger, pre-trigger depth
// and oldest-first FIFO-style readout once the capture completes.
module probe_capture_buffer
  import probe_capture_pkg::*;
#(
  parameter int PROBE_W = 12,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [PROBE_W-1:0] probe,
  input  logic               arm,
  input  logic               abort,
  input  logic [1:0]         trig_mode,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic               ext_trig,
  input  logic [ADDR_W-1:0]  pre_trig,
  input  logic               rd_en,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [2:0]         state,
  output logic               done,
  output logic [ADDR_W:0]    rd_left
);

  function automatic logic [ADDR_W-1:0] clamp_pt(input logic [ADDR_W-1:0] p);
    return (int'(p) > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : p;
  endfunction

  cap_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   pt_q, wptr_q, cnt_q, tptr_q, post_q, rptr_q;
  logic [ADDR_W:0]     rd_left_q;
  logic                prev_match_q, hist_vld_q, rd_valid_q;

  logic                match, trig_hit, wr_en, rd_accept, start, fire, finish;
  logic [ADDR_W-1:0]   arm_pt, post_init, cnt_nxt, trig_ptr;

  assign match     = ((probe ^ trig_value) & trig_mask) == '0;
  assign arm_pt    = clamp_pt(pre_trig);
  assign post_init = ADDR_W'(DEPTH - 1) - pt_q;
  assign cnt_nxt   = cnt_q + 1'b1;
  assign trig_ptr  = fire ? wptr_q : tptr_q;

  // Edge modes need one sample of history since arm before they can fire.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_LEVEL: trig_hit = match;
      TRIG_RISE:  trig_hit = hist_vld_q && match && !prev_match_q;
      TRIG_FALL:  trig_hit = hist_vld_q && !match && prev_match_q;
      default:    trig_hit = ext_trig;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    rd_accept = 1'b0;
    start     = 1'b0;
    fire      = 1'b0;
    finish    = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else if (arm) begin
      start   = 1'b1;
      state_d = (arm_pt == '0) ? ARMED : PRE;
    end else begin
      case (state_q)
        PRE: if (sample_en) begin
          wr_en = 1'b1;
          if (cnt_nxt == pt_q) state_d = ARMED;
        end
        ARMED: if (sample_en) begin
          wr_en = 1'b1;
          if (trig_hit) begin
            fire = 1'b1;
            if (post_init == '0) begin
              finish  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = POST;
            end
          end
        end
        POST: if (sample_en) begin
          wr_en = 1'b1;
          if (post_q == ADDR_W'(1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
        DONE:    rd_accept = rd_en && (rd_left_q != '0);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pt_q         <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      tptr_q       <= '0;
      post_q       <= '0;
      rptr_q       <= '0;
      rd_left_q    <= '0;
      prev_match_q <= 1'b0;
      hist_vld_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (abort) begin
        rd_left_q <= '0;
      end else if (start) begin
        pt_q         <= arm_pt;
        wptr_q       <= '0;
        cnt_q        <= '0;
        prev_match_q <= 1'b0;
        hist_vld_q   <= 1'b0;
        rd_left_q    <= '0;
      end else begin
        if (sample_en) begin
          prev_match_q <= match;
          hist_vld_q   <= 1'b1;
        end
        if (wr_en) begin
          wptr_q <= wptr_q + 1'b1;
          cnt_q  <= cnt_nxt;
        end
        if (fire) begin
          tptr_q <= wptr_q;
          post_q <= post_init;
        end else if (wr_en && state_q == POST) begin
          post_q <= post_q - 1'b1;
        end
        // Oldest retained sample sits pt slots behind the trigger sample.
        if (finish) begin
          rptr_q    <= trig_ptr - pt_q;
          rd_left_q <= (ADDR_W + 1)'(DEPTH);
        end
        if (rd_accept) begin
          rptr_q    <= rptr_q + 1'b1;
          rd_left_q <= rd_left_q - 1'b1;
        end
      end
    end
  end

  capture_ram #(
    .PROBE_W (PROBE_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_data (probe),
    .rd_en   (rd_accept),
    .rd_addr (rptr_q),
    .rd_data (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign done     = (state_q == DONE);
  assign rd_left  = rd_left_q;

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Bench for probe_capture_buffer: directed vector table, hand-written corner sequences
// and randomized captures against a sample-history reference model.
module tb_probe_capture_buffer;

  localparam int PW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  localparam int S_IDLE = 0, S_PRE = 1, S_ARMED = 2, S_POST = 3, S_DONE = 4;

  logic          clk = 1'b0;
  logic          reset, sample_en, arm, abort, ext_trig, rd_en;
  logic [PW-1:0] probe, trig_mask, trig_value;
  logic [1:0]    trig_mode;
  logic [AW-1:0] pre_trig;
  logic [PW-1:0] rd_data;
  logic          rd_valid, done;
  logic [2:0]    state;
  logic [AW:0]   rd_left;

  always #5 clk = ~clk;

  probe_capture_buffer #(.PROBE_W(PW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .probe      (probe),
    .arm        (arm),
    .abort      (abort),
    .trig_mode  (trig_mode),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .ext_trig   (ext_trig),
    .pre_trig   (pre_trig),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .state      (state),
    .done       (done),
    .rd_left    (rd_left)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: full history of samples taken since arm.
  logic [PW-1:0] hp[$];
  bit            hm[$];
  logic [PW-1:0] rdq[$];
  bit            cap_m, done_m, rd_valid_m;
  int            pt_m, trig_idx, rd_idx, rd_left_m;
  logic [PW-1:0] rd_data_m;
  int            se_mode, cyc;
  bit            rnd_ext;

  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] mask;
    logic [PW-1:0] value;
    logic [AW-1:0] pre;
    logic [PW-1:0] first;
    logic [PW-1:0] last;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit mcond(input logic [PW-1:0] p, input logic [PW-1:0] msk,
                               input logic [PW-1:0] val);
    for (int i = 0; i < PW; i++)
      if (msk[i] && (p[i] != val[i])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_state();
    if (!cap_m)        return done_m ? S_DONE : S_IDLE;
    if (trig_idx >= 0) return S_POST;
    if (hp.size() < pt_m) return S_PRE;
    return S_ARMED;
  endfunction

  task automatic step();
    bit hit;
    int k;
    bit m;
    bit vnext;
    if (se_mode == 0)      sample_en = 1'b1;
    else if (se_mode == 1) sample_en = (cyc % 4 == 0);
    else                   sample_en = ($urandom_range(0, 3) != 0);
    if (rnd_ext) ext_trig = ($urandom_range(0, 7) == 0);
    vnext = 1'b0;
    if (reset) begin
      cap_m = 0; done_m = 0; rd_left_m = 0; rd_data_m = '0;
    end else if (abort) begin
      cap_m = 0; done_m = 0; rd_left_m = 0;
    end else if (arm) begin
      hp.delete(); hm.delete();
      cap_m = 1; done_m = 0; trig_idx = -1; rd_left_m = 0; rd_idx = 0;
      pt_m = (int'(pre_trig) > DP - 1) ? DP - 1 : int'(pre_trig);
    end else if (cap_m) begin
      if (sample_en) begin
        k = hp.size();
        m = mcond(probe, trig_mask, trig_value);
        hp.push_back(probe);
        hm.push_back(m);
        if (trig_idx < 0 && k >= pt_m) begin
          hit = 0;
          case (trig_mode)
            2'b00: hit = m;
            2'b01: if (k > 0) hit = m && !hm[k-1];
            2'b10: if (k > 0) hit = !m && hm[k-1];
            default: hit = ext_trig;
          endcase
          if (hit) trig_idx = k;
        end
        if (trig_idx >= 0 && hp.size() == trig_idx + DP - pt_m) begin
          cap_m = 0; done_m = 1; rd_left_m = DP; rd_idx = 0;
        end
      end
    end else if (done_m && rd_en && rd_left_m > 0) begin
      vnext = 1'b1;
      rd_data_m = hp[trig_idx - pt_m + rd_idx];
      rd_idx++;
      rd_left_m--;
    end
    rd_valid_m = vnext;
    @(posedge clk);
    #1;
    cyc++;
    probe = probe + 1'b1;
    check("state", 32'(state), 32'(exp_state()));
    check("done", 32'(done), 32'(done_m));
    check("rd_valid", 32'(rd_valid), 32'(rd_valid_m));
    if (rd_valid_m) check("rd_data", 32'(rd_data), 32'(rd_data_m));
    if (done_m)     check("rd_left", 32'(rd_left), 32'(rd_left_m));
    if (rd_valid === 1'b1) rdq.push_back(rd_data);
  endtask

  task automatic align();
    for (int i = 0; i < 300 && probe != '0; i++) step();
  endtask

  task automatic start_capture();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic run_to_done(input int bound, input string name);
    for (int i = 0; i < bound && !done_m; i++) step();
    check(name, 32'(done), 32'd1);
  endtask

  task automatic readout(input string name);
    rdq.delete();
    rd_en = 1'b1;
    repeat (DP) step();
    check({name, "_left0"}, 32'(rd_left), 32'd0);
    step();
    check({name, "_rd17"}, 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    step();
    check({name, "_count"}, 32'(rdq.size()), 32'(DP));
  endtask

  logic [PW-1:0] tp;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; sample_en = 1; arm = 0; abort = 0; ext_trig = 0; rd_en = 0;
    probe = '0; trig_mode = 0; trig_mask = '0; trig_value = '0; pre_trig = '0;
    se_mode = 0; rnd_ext = 0; cyc = 0;
    cap_m = 0; done_m = 0; rd_valid_m = 0; rd_left_m = 0; rd_data_m = '0;
    pt_m = 0; trig_idx = -1; rd_idx = 0;

    tbl[0] = '{2'b00, 8'hFF, 8'h30, 4'd4,  8'h2C, 8'h3B};
    tbl[1] = '{2'b00, 8'hFF, 8'h05, 4'd0,  8'h05, 8'h14};
    tbl[2] = '{2'b00, 8'hFF, 8'h40, 4'd15, 8'h31, 8'h40};
    tbl[3] = '{2'b00, 8'hF0, 8'h75, 4'd2,  8'h6E, 8'h7D};

    step();
    step();
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_done", 32'(done), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_rd_left", 32'(rd_left), 32'd0);
    reset = 0;

    for (int v = 0; v < 4; v++) begin
      trig_mode = tbl[v].mode; trig_mask = tbl[v].mask;
      trig_value = tbl[v].value; pre_trig = tbl[v].pre;
      align();
      start_capture();
      run_to_done(600, $sformatf("vec%0d_done", v));
      readout($sformatf("vec%0d", v));
      if (rdq.size() == DP) begin
        check($sformatf("vec%0d_first", v), 32'(rdq[0]), 32'(tbl[v].first));
        check($sformatf("vec%0d_last", v), 32'(rdq[DP-1]), 32'(tbl[v].last));
      end
    end

    // Rising edge with the compare already true at arm: must wait for a fresh edge.
    trig_mode = 2'b01; trig_mask = 8'h00; trig_value = 8'h00; pre_trig = 4'd0;
    align();
    start_capture();
    repeat (40) step();
    check("rise_hold_armed", 32'(state), 32'(S_ARMED));
    trig_mask = 8'hFF; trig_value = probe + 8'd20;
    run_to_done(600, "rise_done");
    readout("rise");
    if (rdq.size() == DP) check("rise_trig_word", 32'(rdq[0]), 32'(trig_value));

    // External trigger: ignored in PRE, fires in ARMED, arm mid-POST restarts.
    trig_mode = 2'b11; trig_mask = 8'hFF; trig_value = 8'h00; pre_trig = 4'd8;
    start_capture();
    repeat (3) step();
    ext_trig = 1; step(); ext_trig = 0;
    check("ext_pre_ignored", 32'(state), 32'(S_PRE));
    repeat (10) step();
    check("ext_armed", 32'(state), 32'(S_ARMED));
    ext_trig = 1; step(); ext_trig = 0;
    check("ext_fire_post", 32'(state), 32'(S_POST));
    repeat (3) step();
    start_capture();
    check("arm_mid_post_state", 32'(state), 32'(S_PRE));
    check("arm_mid_post_done", 32'(done), 32'd0);
    repeat (12) step();
    tp = probe;
    ext_trig = 1; step(); ext_trig = 0;
    run_to_done(200, "ext_done");
    rdq.delete();
    rd_en = 1;
    repeat (9) step();
    if (rdq.size() == 9) check("ext_trig_word", 32'(rdq[8]), 32'(tp));
    start_capture();
    rd_en = 0;
    check("arm_mid_read_state", 32'(state), 32'(S_PRE));
    check("arm_mid_read_valid", 32'(rd_valid), 32'd0);
    for (int i = 0; i < 50 && exp_state() != S_ARMED; i++) step();
    abort = 1; step(); abort = 0;
    check("abort_state", 32'(state), 32'(S_IDLE));
    check("abort_done", 32'(done), 32'd0);

    // Sparse sampling: stored samples are one strobe apart.
    se_mode = 1;
    trig_mode = 2'b00; trig_mask = 8'hFC; trig_value = 8'h80; pre_trig = 4'd3;
    align();
    start_capture();
    run_to_done(2000, "sparse_done");
    readout("sparse");
    if (rdq.size() == DP) begin
      check("sparse_spacing", 32'(8'(rdq[1] - rdq[0])), 32'd4);
      check("sparse_trig", 32'(rdq[3] & 8'hFC), 32'h80);
    end
    trig_value = 8'h00; trig_mask = 8'hFF; trig_mode = 2'b11;
    start_capture();
    for (int i = 0; i < 100 && exp_state() != S_ARMED; i++) step();
    reset = 1; step(); reset = 0;
    check("reset_mid_state", 32'(state), 32'(S_IDLE));
    check("reset_mid_done", 32'(done), 32'd0);
    check("reset_mid_valid", 32'(rd_valid), 32'd0);
    se_mode = 0;

    // Randomized captures.
    for (int r = 0; r < 8; r++) begin
      se_mode = 2; rnd_ext = 1;
      trig_mode = 2'($urandom_range(0, 3));
      trig_mask = 8'($urandom_range(1, 255));
      trig_value = 8'($urandom);
      pre_trig = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 20)) step();
      start_capture();
      run_to_done(3000, $sformatf("rnd%0d_done", r));
      rnd_ext = 0;
      readout($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
